// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, framer states and a frame-length helper.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Total clk cycles from start-bit fall to the end of the last stop bit.
    function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                                 input int unsigned data_bits,
                                                 input int unsigned parity,
                                                 input int unsigned stop_bits);
        int unsigned par_bits;
        par_bits = (parity != PARITY_NONE) ? 32'd1 : 32'd0;
        return (32'd1 + data_bits + par_bits + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Valid/ready byte channel between a producer core and the buffered UART transmitter.
interface uart_tx_buffered_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_byte;

    modport master (
        output tx_valid,
        output tx_byte,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_byte,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO holding bytes waiting for the framer.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter with a byte FIFO; queued bytes are framed back-to-back with no idle gap.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_buffered_if.slave             in_if,
    output logic                          tx,
    output logic                          tx_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = 1'(PARITY != PARITY_NONE);
    localparam logic          PAR_INV   = 1'(PARITY == PARITY_ODD);

    tx_state_e            state;
    tx_state_e            state_n;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_n;
    logic [BW-1:0]        bit_idx;
    logic [BW-1:0]        bit_n;
    logic                 stop_idx;
    logic                 stop_n;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic                 par;
    logic                 par_n;
    logic                 tx_n;
    logic                 tx_done_n;
    logic                 busy_n;
    logic                 bit_end;
    logic                 load;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;

    assign in_if.tx_ready = !fifo_full && !rst;
    assign fifo_push      = in_if.tx_valid && in_if.tx_ready;
    assign bit_end        = (cnt == LAST_CNT);

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (in_if.tx_byte),
        .pop     (fifo_pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Framer next-state, datapath and next output values.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_n     = bit_idx;
        stop_n    = stop_idx;
        shreg_n   = shreg;
        par_n     = par;
        load      = 1'b0;
        fifo_pop  = 1'b0;
        tx_n      = 1'b1;
        tx_done_n = 1'b0;
        busy_n    = 1'b0;

        if (state != ST_IDLE) begin
            cnt_n = bit_end ? '0 : cnt + CW'(1);
        end

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                load  = !fifo_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    state_n = ST_DATA;
                    bit_n   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    par_n   = par ^ shreg[0];
                    shreg_n = shreg >> 1;
                    if (bit_idx == LAST_BIT) begin
                        state_n = HAS_PAR ? ST_PARITY : ST_STOP;
                        stop_n  = 1'b0;
                    end else begin
                        bit_n = bit_idx + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_n = ST_STOP;
                    stop_n  = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_idx == LAST_STOP) begin
                        state_n = ST_IDLE;
                        load    = !fifo_empty;
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Pop and start a new frame from IDLE or straight out of the last stop bit.
        if (load) begin
            fifo_pop = 1'b1;
            shreg_n  = fifo_data;
            par_n    = 1'b0;
            cnt_n    = '0;
            state_n  = ST_START;
        end

        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shreg_n[0];
            ST_PARITY: tx_n = par_n ^ PAR_INV;
            default:   tx_n = 1'b1;
        endcase

        tx_done_n = (state_n == ST_STOP) && (cnt_n == LAST_CNT) && (stop_n == LAST_STOP);
        busy_n    = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            stop_idx <= stop_n;
            shreg    <= shreg_n;
            par      <= par_n;
            tx       <= tx_n;
            tx_done  <= tx_done_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: four configurations, frame scoreboard fed at push time.
module tb_uart_tx_buffered;
    import uart_pkg::*;

    localparam int unsigned CPB = 4;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       drv_valid;
    logic [8:0] drv_byte;
    logic [1:0] sel;

    logic [3:0] tx_v;
    logic [3:0] done_v;
    logic [3:0] busy_v;
    logic [3:0] ready_v;
    logic [2:0] cnt_v [4];

    logic       tx_m;
    logic       done_m;
    logic       busy_m;
    logic       ready_m;
    logic [2:0] cnt_m;

    int unsigned cfg_db  [4] = '{8, 8, 8, 7};
    int unsigned cfg_par [4] = '{0, 1, 2, 0};
    int unsigned cfg_sb  [4] = '{1, 1, 1, 2};

    int     checks      = 0;
    int     failures    = 0;
    int     frames      = 0;
    int     gap         = 0;
    int     last_gap    = -1;
    int     done_total  = 0;
    int     cyc         = 0;
    int     last_done_t = 0;
    int     prev_done_t = 0;
    logic   mon_abort   = 1'b0;
    frame_t sb [$];

    always #5 clk = ~clk;

    uart_tx_buffered_if #(.DATA_BITS(8)) if_a ();
    uart_tx_buffered_if #(.DATA_BITS(8)) if_e ();
    uart_tx_buffered_if #(.DATA_BITS(8)) if_o ();
    uart_tx_buffered_if #(.DATA_BITS(7)) if_7 ();

    assign if_a.tx_valid = drv_valid && (sel == 2'd0);
    assign if_e.tx_valid = drv_valid && (sel == 2'd1);
    assign if_o.tx_valid = drv_valid && (sel == 2'd2);
    assign if_7.tx_valid = drv_valid && (sel == 2'd3);
    assign if_a.tx_byte  = drv_byte[7:0];
    assign if_e.tx_byte  = drv_byte[7:0];
    assign if_o.tx_byte  = drv_byte[7:0];
    assign if_7.tx_byte  = drv_byte[6:0];
    assign ready_v       = {if_7.tx_ready, if_o.tx_ready, if_e.tx_ready, if_a.tx_ready};

    assign tx_m    = tx_v[sel];
    assign done_m  = done_v[sel];
    assign busy_m  = busy_v[sel];
    assign ready_m = ready_v[sel];
    assign cnt_m   = cnt_v[sel];

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .in_if(if_a), .tx(tx_v[0]), .tx_done(done_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]));
    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
        .clk(clk), .rst(rst), .in_if(if_e), .tx(tx_v[1]), .tx_done(done_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]));
    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
        .clk(clk), .rst(rst), .in_if(if_o), .tx(tx_v[2]), .tx_done(done_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2]));
    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7 (
        .clk(clk), .rst(rst), .in_if(if_7), .tx(tx_v[3]), .tx_done(done_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bits.
    function automatic frame_t model(input logic [8:0] b, input int unsigned db,
                                     input int unsigned par, input int unsigned sbits);
        frame_t f;
        logic   p;
        int     k;
        f.bits = '0;
        p      = 1'b0;
        for (int i = 0; i < int'(db); i++) begin
            f.bits[1 + i] = b[i];
            p             = p ^ b[i];
        end
        k = 1 + int'(db);
        if (par != 0) begin
            f.bits[k] = (par == 2) ? ~p : p;
            k++;
        end
        for (int s = 0; s < int'(sbits); s++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.n = k;
        return f;
    endfunction

    task automatic sb_push(input logic [8:0] b);
        sb.push_back(model(b, cfg_db[sel], cfg_par[sel], cfg_sb[sel]));
    endtask

    task automatic push(input logic [8:0] b);
        chk("ready_before_push", 32'(ready_m), 32'd1);
        sb_push(b);
        drv_valid = 1'b1;
        drv_byte  = b;
        @(negedge clk);
    endtask

    task automatic wait_frames(input int target, input string tag);
        int t;
        t = 0;
        while (frames < target && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(frames), 32'(target));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_m === 1'b1) begin
            done_total  <= done_total + 1;
            prev_done_t <= last_done_t;
            last_done_t <= cyc;
        end
    end

    // Frame monitor: captures the selected serial line and checks against the scoreboard.
    initial begin : monitor
        frame_t      exp_f;
        logic [15:0] got;
        int          dpos;
        int          dcnt;
        int          fcyc;
        bit          stable;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 || tx_m !== 1'b0) begin
                gap++;
            end else begin
                fcyc    = int'(frame_cycles(CPB, cfg_db[sel], cfg_par[sel], cfg_sb[sel]));
                got     = '0;
                dpos    = -1;
                dcnt    = 0;
                stable  = 1'b1;
                aborted = 1'b0;
                chk("busy_at_start", 32'(busy_m), 32'd1);
                for (int c = 0; c < fcyc; c++) begin
                    if (c > 0) @(negedge clk);
                    if (mon_abort) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c % int'(CPB) == 0) got[c / int'(CPB)] = tx_m;
                    else if (tx_m !== got[c / int'(CPB)]) stable = 1'b0;
                    if (done_m === 1'b1) begin
                        dcnt++;
                        dpos = c;
                    end
                end
                if (aborted) begin
                    mon_abort = 1'b0;
                    gap       = 0;
                end else begin
                    last_gap = gap;
                    gap      = 0;
                    frames++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $error("FAIL unexpected_frame observed=0x%0h expected=none", got);
                    end else begin
                        exp_f = sb.pop_front();
                        chk("frame_bits", 32'(got), 32'(exp_f.bits));
                        chk("bit_stable", 32'(stable), 32'd1);
                        chk("done_count", 32'(dcnt), 32'd1);
                        chk("done_pos", 32'(dpos), 32'(fcyc - 1));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int         acc;
        int         t;
        int         low;
        int         base_done;
        int         base_frames;
        logic [8:0] nxt;

        rst       = 1'b1;
        drv_valid = 1'b0;
        drv_byte  = '0;
        sel       = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_m), 32'd1);
        chk("rst_ready", 32'(ready_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_count", 32'(cnt_m), 32'd0);
        chk("rst_done", 32'(done_m), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single frame 0x41, no parity, with accept-to-start latency.
        push(9'h041);
        drv_valid = 1'b0;
        chk("tx_idle_after_accept", 32'(tx_m), 32'd1);
        chk("count_after_push", 32'(cnt_m), 32'd1);
        @(negedge clk);
        chk("start_latency", 32'(tx_m), 32'd0);
        chk("busy_rise", 32'(busy_m), 32'd1);
        chk("count_after_pop", 32'(cnt_m), 32'd0);
        wait_frames(1, "frames_single");
        @(negedge clk);
        chk("busy_after_frame", 32'(busy_m), 32'd0);
        chk("tx_after_frame", 32'(tx_m), 32'd1);

        // Even and odd parity.
        sel = 2'd1;
        @(negedge clk);
        push(9'h041);
        drv_valid = 1'b0;
        wait_frames(2, "frames_even");
        sel = 2'd2;
        @(negedge clk);
        push(9'h041);
        drv_valid = 1'b0;
        wait_frames(3, "frames_odd");

        // Back-to-back frames.
        sel = 2'd0;
        repeat (2) @(negedge clk);
        push(9'h055);
        push(9'h0AA);
        drv_valid = 1'b0;
        wait_frames(5, "frames_b2b");
        @(negedge clk);
        chk("b2b_gap", 32'(last_gap), 32'd0);
        chk("done_spacing", 32'(last_done_t - prev_done_t), 32'd40);

        // Hold valid high from idle until the FIFO fills.
        drv_byte  = 9'h010;
        drv_valid = 1'b1;
        acc       = 0;
        repeat (8) begin
            if (ready_m === 1'b1) begin
                sb_push(drv_byte);
                acc++;
                nxt = drv_byte + 9'd1;
            end else begin
                nxt = drv_byte;
            end
            @(negedge clk);
            drv_byte = nxt;
        end
        chk("accepted_when_full", 32'(acc), 32'd5);
        chk("ready_when_full", 32'(ready_m), 32'd0);
        chk("count_when_full", 32'(cnt_m), 32'd4);
        t = 0;
        while (done_m !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("first_done_seen", 32'(done_m), 32'd1);
        chk("ready_at_last_stop", 32'(ready_m), 32'd0);
        @(negedge clk);
        chk("ready_after_pop", 32'(ready_m), 32'd1);
        sb_push(drv_byte);
        @(negedge clk);
        drv_valid = 1'b0;
        wait_frames(11, "frames_full");
        @(negedge clk);
        chk("full_run_gap", 32'(last_gap), 32'd0);

        // Reset mid-DATA with two bytes queued.
        repeat (2) @(negedge clk);
        push(9'h031);
        push(9'h032);
        push(9'h033);
        drv_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("queued_before_rst", 32'(cnt_m), 32'd2);
        mon_abort = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_tx", 32'(tx_m), 32'd1);
        chk("rst_mid_count", 32'(cnt_m), 32'd0);
        chk("rst_mid_busy", 32'(busy_m), 32'd0);
        sb.delete();
        base_done   = done_total;
        base_frames = frames;
        low         = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_m !== 1'b1) low++;
        end
        chk("no_tx_after_rst", 32'(low), 32'd0);
        chk("no_done_after_rst", 32'(done_total), 32'(base_done));
        chk("no_frame_after_rst", 32'(frames), 32'(base_frames));

        // Seven data bits, two stop bits.
        sel = 2'd3;
        @(negedge clk);
        push(9'h07F);
        drv_valid = 1'b0;
        wait_frames(base_frames + 1, "frames_7n2");
        @(negedge clk);
        chk("busy_after_7n2", 32'(busy_m), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised UART transmitter with an internal transmit FIFO and valid/ready byte input. It generalises the single-byte start/done transmitter to configurable data width, parity and stop bits, and it sends queued bytes back-to-back with no idle gap. It sits between a byte-producing core (debug/telemetry streamer, SEAsynth host link) and the board TX pin.

## Interface
Parameters:
- CLKS_PER_BIT, 87: clk cycles per bit period; must be ≥ 2.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  producer has a byte on tx_byte.
- tx_ready  out  1  FIFO can accept; transfer on tx_valid && tx_ready at a clk edge.
- tx_byte  in  DATA_BITS  byte to queue.
- tx  out  1  serial line, idle high, registered.
- tx_done  out  1  one-cycle pulse per completed frame.
- busy  out  1  high while the framer is in any state other than IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued.

## Operation
- Reset values: tx=1, tx_done=0, busy=0, fifo_count=0, tx_ready=0 while rst is high. FIFO pointers and framer state are cleared.
- tx_ready = !full && !rst. A push while the FIFO is full cannot occur. A simultaneous push and pop when not full leaves the count unchanged.
- Framer FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If the FIFO is non-empty, pop at the next edge, load the shift register, and enter START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: DATA_BITS bit periods, LSB first.
- PARITY: skipped when PARITY=0. Otherwise one bit period; bit = XOR of data (even) or its inverse (odd).
- STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
- At the last cycle of STOP: if the FIFO is non-empty, pop and enter START directly (zero idle gap). Otherwise enter IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. A bit index counts data bits.
- Reset mid-frame: tx=1 and busy=0 after the reset edge, FIFO flushed, no tx_done pulse for the aborted frame.

## Timing
- Byte accepted at edge k into an empty FIFO with the framer in IDLE → pop at edge k+1, tx=0 from edge k+1. One-cycle accept-to-start latency.
- Frame length F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- tx_done is high for exactly the final clk cycle of the last stop bit, once per frame.
- busy rises with tx=0 of the first start bit. It stays high across back-to-back frames and falls on the first IDLE cycle.
- fifo_count updates the cycle after the push/pop edge.

## Structure
- Shared package uart_pkg holds:
  - parity encoding constants PARITY_NONE/EVEN/ODD,
  - the framer state enum,
  - a function computing F for benches.
- Sub-module uart_tx_fifo: synchronous FIFO with DATA_BITS width, FIFO_DEPTH depth, push/pop/full/empty/count, synchronous reset.
- uart_tx_buffered contains the FSM, baud counter, shift register and parity accumulator.

## Test plan
- CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1. Push 0x41 → tx bit sequence 0,1,0,0,0,0,0,1,0,1, each bit held 4 cycles. tx_done pulses in cycle 40 after tx falls. busy=0 afterwards.
- Same config with PARITY=1 and then PARITY=2, push 0x41 → parity bit 0 (even) / 1 (odd). Frame is 44 cycles.
- Push 0x55 then 0xAA on consecutive cycles → 80 contiguous frame cycles with no idle high gap between stop and start. Two tx_done pulses 40 cycles apart.
- FIFO_DEPTH=4, tx_valid held high from idle → exactly 5 bytes accepted (one popped immediately), tx_ready low after the 5th. tx_ready returns one cycle after the next pop.
- Assert rst for 1 cycle mid-DATA with 2 bytes queued → tx=1 and fifo_count=0 next cycle, no tx_done, no further frame transmitted.
- DATA_BITS=7, STOP_BITS=2, PARITY=0, push 0x7F → start, seven 1s, two stop periods. Frame is 40 cycles at CLKS_PER_BIT=4.
